tbu_param: RTL and testbench

- Parametrised traceback unit for the Viterbi decoder, supporting any constraint length K, including the 8-state K=4 trellis.
- Sits after the survivor-path memory, which presents two decision banks per cycle.
- Walks the trellis backwards one step per cycle, starting from a reset state or from a best-metric start state.
- Emits one decoded bit per cycle while the output bank is selected, and counts traceback depth to flag block completion.

---
 rtl/tbu_param_pkg.sv | 19 +
 rtl/tbu_param_if.sv | 30 +++
 rtl/tbu_param_step.sv | 25 ++
 rtl/tbu_param.sv | 99 +++++++++
 tb/tb_tbu_param.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/tbu_param_pkg.sv
// Shared Viterbi decoder constants: trellis sizing helpers and default depths.
package viterbi_pkg;

   localparam int unsigned K_DEFAULT        = 4;
   localparam int unsigned TB_DEPTH_DEFAULT = 16;

   function automatic int unsigned calc_m(input int unsigned k);
      return k - 1;
   endfunction

   function automatic int unsigned calc_ns(input int unsigned k);
      return 32'd1 << (k - 1);
   endfunction

   localparam int unsigned M_DEFAULT = calc_m(K_DEFAULT);

   typedef logic [M_DEFAULT-1:0] state_t;

endpackage

// File: rtl/tbu_param_if.sv
// Traceback unit bus: decision banks and control in, decoded stream and debug state out.
interface tbu_param_if #(
   parameter int unsigned K = viterbi_pkg::K_DEFAULT
) ();
   import viterbi_pkg::*;

   localparam int unsigned M  = calc_m(K);
   localparam int unsigned NS = calc_ns(K);

   logic          enable;
   logic          selection;
   logic [NS-1:0] d_in_0;
   logic [NS-1:0] d_in_1;
   logic [M-1:0]  best_state;
   logic          d_o;
   logic          wr_en;
   logic          blk_done;
   logic [M-1:0]  cur_state;

   modport master (
      output enable, selection, d_in_0, d_in_1, best_state,
      input  d_o, wr_en, blk_done, cur_state
   );

   modport slave (
      input  enable, selection, d_in_0, d_in_1, best_state,
      output d_o, wr_en, blk_done, cur_state
   );

endinterface

// File: rtl/tbu_param_step.sv
// One backward trellis step: pick the survivor decision bit and form the predecessor state.
module tbu_step #(
   parameter  int unsigned K  = viterbi_pkg::K_DEFAULT,
   localparam int unsigned M  = viterbi_pkg::calc_m(K),
   localparam int unsigned NS = viterbi_pkg::calc_ns(K)
) (
   input  logic [M-1:0]  state,
   input  logic [NS-1:0] d_in_0,
   input  logic [NS-1:0] d_in_1,
   input  logic          selection,
   output logic          dec,
   output logic [M-1:0]  next_state
);
   import viterbi_pkg::*;

   assign dec = selection ? d_in_1[state] : d_in_0[state];

   // A single-bit state has nothing to shift, so the decision becomes the whole state.
   if (M > 1) begin : g_shift
      assign next_state = {dec, state[M-1:1]};
   end else begin : g_single
      assign next_state = dec;
   end

endmodule

// File: rtl/tbu_param.sv
// Parametrised Viterbi traceback unit; define TBU_BEST_STATE_EN to restart from best_state
// instead of state 0.
module tbu_param #(
   parameter int unsigned K        = viterbi_pkg::K_DEFAULT,
   parameter int unsigned TB_DEPTH = viterbi_pkg::TB_DEPTH_DEFAULT
) (
   input logic        clk,
   input logic        rst,
   tbu_param_if.slave bus
);
   import viterbi_pkg::*;

   localparam int unsigned M     = calc_m(K);
   localparam int unsigned CNT_W = $clog2(TB_DEPTH + 1);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TB_DEPTH);
   localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(TB_DEPTH - 1);

   logic [M-1:0]     state;
   logic [M-1:0]     state_d;
   logic [M-1:0]     step_state;
   logic [M-1:0]     sv;
   logic             dec;
   logic             sel_q;
   logic             sel_edge;
   logic             emit;
   logic             done_d;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_base;
   logic [CNT_W-1:0] cnt_d;
   logic             d_o_q;
   logic             wr_en_q;
   logic             blk_done_q;

`ifdef TBU_BEST_STATE_EN
   assign sv = bus.best_state;
`else
   logic unused_best;
   assign sv          = '0;
   assign unused_best = ^bus.best_state;
`endif

   tbu_step #(.K(K)) u_step (
      .state      (state),
      .d_in_0     (bus.d_in_0),
      .d_in_1     (bus.d_in_1),
      .selection  (bus.selection),
      .dec        (dec),
      .next_state (step_state)
   );

   // On a selection edge the count restarts at zero, so the edge cycle itself
   // may already emit the first bit of the new output phase.
   always_comb begin
      sel_edge = sel_q ^ bus.selection;
      cnt_base = sel_edge ? '0 : cnt;
      emit     = bus.enable && bus.selection && (cnt_base < DEPTH_C);
      done_d   = emit && (cnt_base == LAST_C);
      state_d  = step_state;
      cnt_d    = cnt_base;
      if (!bus.enable) begin
         state_d = sv;
         cnt_d   = '0;
      end else begin
         if (sel_edge) begin
            state_d = sv;
         end
         if (emit) begin
            cnt_d = cnt_base + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= '0;
         sel_q      <= 1'b0;
         cnt        <= '0;
         d_o_q      <= 1'b0;
         wr_en_q    <= 1'b0;
         blk_done_q <= 1'b0;
      end else begin
         state      <= state_d;
         sel_q      <= bus.selection;
         cnt        <= cnt_d;
         wr_en_q    <= emit;
         blk_done_q <= done_d;
         if (emit) begin
            d_o_q <= dec;
         end
      end
   end

   assign bus.d_o       = d_o_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.blk_done  = blk_done_q;
   assign bus.cur_state = state;

endmodule

// File: tb/tb_tbu_param.sv
// Directed bench for tbu_param with K=4, TB_DEPTH=4; expected values are hand-derived.
module tb_tbu_param;
   import viterbi_pkg::*;

   localparam int unsigned K        = 4;
   localparam int unsigned TB_DEPTH = 4;

`ifdef TBU_BEST_STATE_EN
   localparam logic [2:0] SV_ALT = 3'd3;
`else
   localparam logic [2:0] SV_ALT = 3'd0;
`endif

   logic clk = 1'b0;
   logic rst;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   tbu_param_if #(.K(K)) bus ();

   tbu_param #(.K(K), .TB_DEPTH(TB_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic wr, input logic dout,
                          input logic blk, input state_t st);
      chk({tag, ".wr_en"},     32'(bus.wr_en),     32'(wr));
      chk({tag, ".d_o"},       32'(bus.d_o),       32'(dout));
      chk({tag, ".blk_done"},  32'(bus.blk_done),  32'(blk));
      chk({tag, ".cur_state"}, 32'(bus.cur_state), 32'(st));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst            = 1'b1;
      bus.enable     = 1'b0;
      bus.selection  = 1'b0;
      bus.d_in_0     = '0;
      bus.d_in_1     = '0;
      bus.best_state = '0;

      // Reset with random inputs
      for (int i = 0; i < 3; i++) begin
         bus.enable     = 1'($urandom);
         bus.selection  = 1'($urandom);
         bus.d_in_0     = 8'($urandom);
         bus.d_in_1     = 8'($urandom);
         bus.best_state = 3'($urandom);
         tick();
         chk_out($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 3'd0);
      end

      // Output phase start (rising edge), then a single step from state 0
      rst            = 1'b0;
      bus.enable     = 1'b1;
      bus.selection  = 1'b1;
      bus.d_in_0     = 8'h00;
      bus.d_in_1     = 8'h01;
      bus.best_state = 3'd0;
      tick(); chk_out("phase_start", 1'b1, 1'b1, 1'b0, 3'd0);
      tick(); chk_out("single_step", 1'b1, 1'b1, 1'b0, 3'd4);

      // Chain through all-ones decisions to saturation
      bus.d_in_1 = 8'hFF;
      tick(); chk_out("chain3",     1'b1, 1'b1, 1'b0, 3'd6);
      tick(); chk_out("chain4",     1'b1, 1'b1, 1'b1, 3'd7);
      tick(); chk_out("chain_sat1", 1'b0, 1'b1, 1'b0, 3'd7);
      tick(); chk_out("chain_sat2", 1'b0, 1'b1, 1'b0, 3'd7);

      // Bank-0 phase: no output, state stays at 0
      bus.selection = 1'b0;
      bus.d_in_0    = 8'hAA;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk_out($sformatf("bank0_%0d", i), 1'b0, 1'b1, 1'b0, 3'd0);
      end

      // Walk to state 5, then drop selection mid-phase
      bus.selection = 1'b1;
      bus.d_in_1    = 8'h05;
      tick(); chk_out("walk0", 1'b1, 1'b1, 1'b0, 3'd0);
      tick(); chk_out("walk1", 1'b1, 1'b1, 1'b0, 3'd4);
      tick(); chk_out("walk2", 1'b1, 1'b0, 1'b0, 3'd2);
      tick(); chk_out("walk3", 1'b1, 1'b1, 1'b1, 3'd5);
      bus.selection  = 1'b0;
      bus.best_state = 3'b011;
      tick(); chk_out("sel_fall", 1'b0, 1'b1, 1'b0, SV_ALT);
      bus.best_state = 3'd0;

      // Enable drop during an output phase
      bus.selection = 1'b1;
      bus.d_in_1    = 8'hFF;
      tick(); chk_out("en_pre0", 1'b1, 1'b1, 1'b0, 3'd0);
      tick(); chk_out("en_pre1", 1'b1, 1'b1, 1'b0, 3'd4);
      bus.enable = 1'b0;
      tick(); chk_out("en_off0", 1'b0, 1'b1, 1'b0, 3'd0);
      tick(); chk_out("en_off1", 1'b0, 1'b1, 1'b0, 3'd0);
      bus.enable = 1'b1;
      tick(); chk_out("en_on0", 1'b1, 1'b1, 1'b0, 3'd4);
      tick(); chk_out("en_on1", 1'b1, 1'b1, 1'b0, 3'd6);
      tick(); chk_out("en_on2", 1'b1, 1'b1, 1'b0, 3'd7);
      tick(); chk_out("en_on3", 1'b1, 1'b1, 1'b1, 3'd7);
      tick(); chk_out("en_on4", 1'b0, 1'b1, 1'b0, 3'd7);

      // Reset on the cycle that would have completed the block
      bus.selection = 1'b0;
      tick(); chk_out("rst_pre0", 1'b0, 1'b1, 1'b0, 3'd0);
      bus.selection = 1'b1;
      tick(); chk_out("rst_pre1", 1'b1, 1'b1, 1'b0, 3'd0);
      tick(); chk_out("rst_pre2", 1'b1, 1'b1, 1'b0, 3'd4);
      tick(); chk_out("rst_pre3", 1'b1, 1'b1, 1'b0, 3'd6);
      rst = 1'b1;
      tick(); chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 3'd0);
      rst = 1'b0;
      tick(); chk_out("rst_post0", 1'b1, 1'b1, 1'b0, 3'd0);
      tick(); chk_out("rst_post1", 1'b1, 1'b1, 1'b0, 3'd4);
      tick(); chk_out("rst_post2", 1'b1, 1'b1, 1'b0, 3'd6);
      tick(); chk_out("rst_post3", 1'b1, 1'b1, 1'b1, 3'd7);
      tick(); chk_out("rst_post4", 1'b0, 1'b1, 1'b0, 3'd7);

      // Selection edge on the same cycle enable falls
      bus.selection = 1'b0;
      bus.enable    = 1'b0;
      tick(); chk_out("edge_en_off", 1'b0, 1'b1, 1'b0, 3'd0);
      bus.selection = 1'b1;
      bus.enable    = 1'b1;
      bus.d_in_1    = 8'hFE;
      tick(); chk_out("edge_en_on", 1'b1, 1'b0, 1'b0, 3'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
